// File: rtl/spi_pkg.sv
// spi_pkg: frame layout constants, FSM state type and frame builder for the 16-bit SPI master
package spi_pkg;
  localparam int FRAME_BITS     = 16;
  localparam int MODE_BIT       = 1;
  localparam int ADDR_MSB_BIT   = 2;
  localparam int ADDR_BITS      = 4;
  localparam int DATA_FIRST_BIT = 9;
  localparam int DATA_BITS      = 8;
  localparam logic MODE_READ    = 1'b1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  // Wire bit n (1 = first on the wire) lives at frame[FRAME_BITS-n]; reads carry a zero data field.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic mode, input logic [ADDR_BITS-1:0] a,
                                                        input logic [DATA_BITS-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-MODE_BIT] = mode;
    f[FRAME_BITS-ADDR_MSB_BIT -: ADDR_BITS] = a;
    if (mode != MODE_READ) f[FRAME_BITS-DATA_FIRST_BIT -: DATA_BITS] = d;
    return f;
  endfunction
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period counter that strobes one cycle ahead of each spiclk edge
// Ports: clk, rstn (async active-low), en (counts only while high),
//        rise / fall (single-cycle strobes: spiclk goes high / low on the next edge).
// The first high phase is started by the master itself, so the phase starts high when enabled.
module spi_clkgen #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(CLKDIV + 1);
  logic [W-1:0] hc;
  logic ph;
  logic last;
  assign last = hc == W'(CLKDIV - 1);
  assign rise = en && last && !ph;
  assign fall = en && last && ph;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hc <= '0;
      ph <= 1'b1;
    end else if (!en) begin
      hc <= '0;
      ph <= 1'b1;
    end else if (last) begin
      hc <= '0;
      ph <= ~ph;
    end else begin
      hc <= hc + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: initiator for the 16-bit SPI register-access frame {rnw, addr, 3'b000, data}
// Ports: clk, rstn (async active-low); start/rnw/addr/wrdata request (sampled while idle);
//        busy, done (one-cycle pulse), rddata (last read result);
//        spien (select, active high), spiclk (idles low), spidout (MOSI), spidin (MISO).
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKDIV  = 4,
  parameter int IDLEGAP = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       rnw,
  input  logic [3:0] addr,
  input  logic [7:0] wrdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rddata,
  output logic       spien,
  output logic       spiclk,
  output logic       spidout,
  input  logic       spidin
);
  localparam int CMAX = CLKDIV > IDLEGAP ? CLKDIV : IDLEGAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKDIV - 1);
  // The done cycle itself is the last low-select cycle, so GAP only covers IDLEGAP-1 cycles.
  localparam logic [CW-1:0] G_LAST = CW'(IDLEGAP - 2);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);
  localparam logic [4:0] CAP_FROM = 5'(DATA_FIRST_BIT - 1);
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [FRAME_BITS-1:0] frame, frame_new;
  logic [4:0] bitc;
  logic [DATA_BITS-1:0] cap;
  logic rd_q, accept, rise, fall, shifting, first_rise, next_bit;
  logic busy_d, done_d, spien_d, spiclk_d, spidout_d;
  logic [7:0] rddata_d;
  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk (clk),
    .rstn(rstn),
    .en  (shifting),
    .rise(rise),
    .fall(fall)
  );
  assign shifting   = state == SHIFT;
  assign accept     = state == IDLE && start;
  // Bit 1 rises on the SETUP->SHIFT edge; the clkgen handles the remaining edges.
  assign first_rise = state == SETUP && state_d == SHIFT;
  // A rise strobe with all 16 bits sent marks the end of the last low phase instead.
  assign next_bit   = rise && bitc != LAST_BIT;
  assign frame_new  = build_frame(rnw, addr, wrdata);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      frame   <= '0;
      bitc    <= '0;
      cap     <= '0;
      rd_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rddata  <= '0;
      spien   <= 1'b0;
      spiclk  <= 1'b0;
      spidout <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= state_d != state ? '0 : cnt + 1'b1;
      frame   <= accept ? frame_new : fall ? frame << 1 : frame;
      rd_q    <= accept ? rnw : rd_q;
      bitc    <= first_rise ? 5'd1 : next_bit ? bitc + 5'd1 : bitc;
      cap     <= next_bit && bitc >= CAP_FROM ? {cap[DATA_BITS-2:0], spidin} : cap;
      busy    <= busy_d;
      done    <= done_d;
      rddata  <= rddata_d;
      spien   <= spien_d;
      spiclk  <= spiclk_d;
      spidout <= spidout_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = cnt == C_LAST ? SHIFT : SETUP;
      SHIFT:   state_d = rise && bitc == LAST_BIT ? HOLD : SHIFT;
      HOLD:    state_d = cnt != C_LAST ? HOLD : IDLEGAP > 1 ? GAP : IDLE;
      GAP:     state_d = cnt == G_LAST ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_d    = state_d != IDLE;
    done_d    = state != IDLE && state_d == IDLE;
    spien_d   = state_d inside {SETUP, SHIFT, HOLD};
    spiclk_d  = state_d == SHIFT && (first_rise || next_bit || (spiclk && !fall));
    // The frame shifts left on every fall, so frame[FRAME_BITS-2] is always the next wire bit;
    // zeros shifted in make MOSI drop to 0 after the 16th fall.
    spidout_d = accept ? frame_new[FRAME_BITS-MODE_BIT] : fall ? frame[FRAME_BITS-2] : spidout;
    rddata_d  = done_d && rd_q == MODE_READ ? cap : rddata;
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master with a behavioural slave on the wire
module tb_spi_master;
  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rd;
  } exp_t;
  logic clk = 0, rstn = 0, start = 0, rnw = 0, sel = 0, miso = 0;
  logic [3:0] addr = 0;
  logic [7:0] wrdata = 0, srd = 0;
  logic busy_v[2], done_v[2], en_v[2], sck_v[2], dout_v[2];
  logic [7:0] rd_v[2];
  logic busy, done, spien, spiclk, spidout;
  logic [7:0] rddata;
  logic [7:0] rdm[2];
  exp_t sb[$];
  exp_t e_m;
  int total = 0, bad = 0;
  logic [15:0] sh = 0;
  int n = 0, last_n = 0;
  always #5 clk = ~clk;
  spi_master #(.CLKDIV(2), .IDLEGAP(2)) u_c2 (
    .clk(clk), .rstn(rstn), .start(start && !sel), .rnw(rnw), .addr(addr), .wrdata(wrdata),
    .busy(busy_v[0]), .done(done_v[0]), .rddata(rd_v[0]), .spien(en_v[0]), .spiclk(sck_v[0]),
    .spidout(dout_v[0]), .spidin(miso));
  spi_master #(.CLKDIV(1), .IDLEGAP(2)) u_c1 (
    .clk(clk), .rstn(rstn), .start(start && sel), .rnw(rnw), .addr(addr), .wrdata(wrdata),
    .busy(busy_v[1]), .done(done_v[1]), .rddata(rd_v[1]), .spien(en_v[1]), .spiclk(sck_v[1]),
    .spidout(dout_v[1]), .spidin(miso));
  assign busy    = busy_v[sel];
  assign done    = done_v[sel];
  assign rddata  = rd_v[sel];
  assign spien   = en_v[sel];
  assign spiclk  = sck_v[sel];
  assign spidout = dout_v[sel];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // slave: samples MOSI on spiclk rise, presents read data MSB first after each fall from bit 8 on
  initial forever begin
    @(posedge spiclk or negedge spiclk or negedge spien);
    if (!spien) begin
      if (n != 0) last_n = n;
      n = 0;
      miso = 0;
    end else if (spiclk) begin
      sh = {sh[14:0], spidout};
      n++;
    end else if (n >= 8 && n < 16) miso = srd[3'(15 - n)];
  end
  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (rstn && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with nothing pending, expected no done");
      end else begin
        e_m = sb.pop_front();
        check("frame", sh, e_m.frame);
        check("rddata", rddata, e_m.rd);
        check("rise_count", last_n, 16);
      end
    end
  end
  // wire timing monitor: spiclk phases and select width
  initial begin
    int hi_len, per_len, en_len, cd;
    bit seen, psck, pen;
    hi_len = 0; per_len = 0; en_len = 0; seen = 0; psck = 0; pen = 0;
    forever begin
      @(negedge clk);
      cd = sel ? 1 : 2;
      if (spien) begin
        en_len++;
        per_len++;
        if (spiclk && !psck) begin
          if (seen) check("sck_period", per_len, 2 * cd);
          seen = 1;
          per_len = 0;
          hi_len = 1;
        end else if (spiclk) hi_len++;
        else if (psck) check("sck_high", hi_len, cd);
      end else begin
        if (pen && rstn) check("spien_len", en_len, 34 * cd);
        en_len = 0; per_len = 0; hi_len = 0; seen = 0;
      end
      psck = spiclk;
      pen = spien;
    end
  end
  task automatic txn(input logic r, input logic [3:0] a, input logic [7:0] w, input bit pulses,
                     input bit timed);
    int k, hi, cd;
    bit got;
    cd = sel ? 1 : 2;
    k = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("idle_before_start", busy, 0);
    rnw = r; addr = a; wrdata = w; start = 1;
    if (r) rdm[sel] = srd;
    sb.push_back('{frame: {r, a, 3'b000, r ? 8'h00 : w}, rd: rdm[sel]});
    @(negedge clk);
    start = 0; k = 1; got = 0; hi = 0;
    while (!got && k < 2000) begin
      if (pulses && (k == 10 || k == 20 || k == 30)) begin
        start = 1;
        addr = 4'h7;
      end else start = 0;
      if (spien) hi++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    start = 0;
    check("done_seen", got, 1);
    if (timed) begin
      check("done_cycle", k, 34 * cd + 2);
      check("spien_cycles", hi, 34 * cd);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end
  initial begin
    int k, lo;
    bit got;
    rdm[0] = 0;
    rdm[1] = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1 check("reset_outputs", {busy, done, spien, spiclk, spidout, rddata}, 0);
    end
    sel = 0;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    txn(0, 4'hA, 8'h5C, 0, 1);
    srd = 8'hC3;
    txn(1, 4'h3, 8'hA5, 0, 1);
    check("slave_addr", sh[14:11], 4'h3);
    txn(0, 4'h5, 8'h81, 1, 1);
    srd = 8'h5A; rnw = 1; addr = 4'h9; wrdata = 8'h00; start = 1;
    @(negedge clk);
    start = 0; k = 0;
    while (n < 7 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("bit7_reached", n, 7);
    #2 rstn = 0;
    #1 check("async_outputs", {busy, done, spien, spiclk, spidout}, 0);
    check("async_rddata", rddata, 0);
    rdm[0] = 0;
    rdm[1] = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    txn(0, 4'hF, 8'h3C, 0, 1);
    repeat (2) @(negedge clk);
    sel = 1;
    srd = 8'hFF;
    txn(1, 4'h4, 8'h00, 0, 1);
    srd = 8'h00;
    txn(1, 4'h4, 8'hFF, 0, 1);
    repeat (2) @(negedge clk);
    srd = 8'h69;
    rnw = 0; addr = 4'h1; wrdata = 8'h96; start = 1;
    sb.push_back('{frame: 16'h0896, rd: rdm[1]});
    @(negedge clk);
    rnw = 1; addr = 4'h2; wrdata = 8'hEE;
    rdm[1] = 8'h69;
    sb.push_back('{frame: 16'h9000, rd: 8'h69});
    k = 1; lo = 0; got = 0;
    while (!got && k < 500) begin
      if (!spien) lo++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("b2b_first_done", got, 1);
    check("b2b_gap_low", lo, 2);
    @(negedge clk);
    check("b2b_spien_next", spien, 1);
    start = 0;
    k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("b2b_second_done", done, 1);
    repeat (5) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
